// File: rtl/ls48_pkg.sv
// Shared encodings for the rate sequencer: FSM state codes and divider rate selects.
package ls48_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    RATE_1HZ  = 2'd0,
    RATE_2HZ  = 2'd1,
    RATE_4HZ  = 2'd2,
    RATE_10HZ = 2'd3
  } rate_e;

  localparam int MAX_COUNT_LIMIT = 99;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter with a terminal flag; the terminal value is fixed
// at elaboration and the terminal step either wraps or holds.
module bcd2_counter
  import ls48_pkg::*;
#(
  parameter int MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       clr,
  input  logic       hold_at_term,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       term
);

  if (MAX_COUNT < 1 || MAX_COUNT > MAX_COUNT_LIMIT) begin : g_bad_max_count
    $error("bcd2_counter: MAX_COUNT must be within 1..99");
  end

  localparam logic [3:0] TERM_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] TERM_ONES = 4'(MAX_COUNT % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max, at_zero;

  assign at_max  = (tens_q == TERM_TENS) && (ones_q == TERM_ONES);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign term    = up_dn ? at_max : at_zero;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (en) begin
      if (term) begin
        if (!hold_at_term) begin
          tens_d = up_dn ? 4'd0 : TERM_TENS;
          ones_d = up_dn ? 4'd0 : TERM_ONES;
        end
      end else if (up_dn) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/rate_seq_ctrl.sv
// Run/pause/clear sequencer: turns rising edges of the selected divider output into
// 1-cycle count enables for a 2-digit BCD counter.
module rate_seq_ctrl
  import ls48_pkg::*;
#(
  parameter int MAX_COUNT = 99,
  parameter bit AUTO_STOP = 1'b0
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       clk_4hz,
  input  logic       clk_10hz,
  input  logic [1:0] rate_sel,
  input  logic       up_dn,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       tick,
  output logic       wrap,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [1:0] state
);

  state_e     state_q, state_d;
  logic [3:0] lvl, rise;
  logic [3:0] prev_q, prev_d;
  logic [1:0] rate_q, rate_d;
  logic       tick_q, tick_d;
  logic       wrap_q, wrap_d;
  logic       sel_rise, step, term;

  // Bit index matches the rate code, so rise[rate_q] picks the selected divider.
  assign lvl      = {clk_10hz, clk_4hz, clk_2hz, clk_1hz};
  assign prev_d   = lvl;
  assign rise     = lvl & ~prev_q;
  assign sel_rise = rise[rate_q];

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    step    = 1'b0;
    if (state_q != ST_RUN) rate_d = rate_sel;
    case (state_q)
      ST_IDLE:  if (!clear && !stop && start) state_d = ST_RUN;
      ST_RUN: begin
        if (clear)     state_d = ST_IDLE;
        else if (stop) state_d = ST_PAUSE;
        else if (sel_rise) begin
          step = 1'b1;
          if (AUTO_STOP && term) state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (clear)               state_d = ST_IDLE;
        else if (!stop && start) state_d = ST_RUN;
      end
      ST_DONE:  if (clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    tick_d = step;
    wrap_d = step && term;
  end

  // NOTE: async reset clears every register, including edge history, so a divider
  // level already high at reset release is seen as a rise.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prev_q  <= 4'd0;
      rate_q  <= 2'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      rate_q  <= rate_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  bcd2_counter #(
    .MAX_COUNT (MAX_COUNT)
  ) u_counter (
    .clk          (clk_50M),
    .rst_n        (rst_n),
    .en           (step),
    .up_dn        (up_dn),
    .clr          (clear),
    .hold_at_term (AUTO_STOP),
    .tens         (bcd_tens),
    .ones         (bcd_ones),
    .term         (term)
  );

  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule

// File: tb/tb_rate_seq_ctrl.sv
// Bench for rate_seq_ctrl: a wrapping 0..99 instance and an auto-stop 0..15 instance
// share stimulus and are compared against an integer-count reference model.
module tb_rate_seq_ctrl;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] lvl     = 4'd0;
  logic [3:0] lvl_pos = 4'd0;
  logic [1:0] rate_sel = 2'd0;
  logic       up_dn = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;

  logic       tick0, wrap0, tick1, wrap1;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic [1:0] state0, state1;

  int n_cmp = 0;
  int n_bad = 0;
  int div_cnt = 0;

  rate_seq_ctrl #(.MAX_COUNT(99), .AUTO_STOP(1'b0)) u_wrap (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .clk_1hz(lvl[0]), .clk_2hz(lvl[1]), .clk_4hz(lvl[2]), .clk_10hz(lvl[3]),
    .rate_sel(rate_sel), .up_dn(up_dn), .start(start), .stop(stop), .clear(clear),
    .tick(tick0), .wrap(wrap0), .bcd_tens(tens0), .bcd_ones(ones0), .state(state0)
  );

  rate_seq_ctrl #(.MAX_COUNT(15), .AUTO_STOP(1'b1)) u_auto (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .clk_1hz(lvl[0]), .clk_2hz(lvl[1]), .clk_4hz(lvl[2]), .clk_10hz(lvl[3]),
    .rate_sel(rate_sel), .up_dn(up_dn), .start(start), .stop(stop), .clear(clear),
    .tick(tick1), .wrap(wrap1), .bcd_tens(tens1), .bcd_ones(ones1), .state(state1)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic int per(input int k);
    case (k)
      0:       return 40;
      1:       return 20;
      2:       return 10;
      default: return 4;
    endcase
  endfunction

  // Free-running dividers, 50% duty, updated away from the active edge.
  always @(negedge clk_50M) begin
    div_cnt <= div_cnt + 1;
    for (int k = 0; k < 4; k++) lvl[k] <= (((div_cnt + 1) % per(k)) < per(k) / 2);
  end

  always @(posedge clk_50M) lvl_pos <= lvl;

  // Reference model: the count is a plain integer; st 0..3 = idle/run/pause/done.
  typedef struct {
    int       st;
    int       cnt;
    bit       tick;
    bit       wrap;
    bit [3:0] prev;
    int       rate;
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.cnt = 0; r.tick = 0; r.wrap = 0; r.prev = 4'd0; r.rate = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input bit [3:0] lv, input int rs,
                                 input bit up, input bit st_c, input bit sp_c,
                                 input bit cl_c, input int maxc, input bit autos);
    mdl_t n = c;
    bit [3:0] rs_bits = lv & ~c.prev;
    bit counted = (c.st == 1) && rs_bits[c.rate] && !cl_c && !sp_c;
    n.prev = lv;
    n.tick = 0;
    n.wrap = 0;
    if (c.st != 1) n.rate = rs;
    if (cl_c) begin
      n.st = 0; n.cnt = 0;
    end else if (sp_c) begin
      if (c.st == 1) n.st = 2;
    end else if (st_c) begin
      if (c.st == 0 || c.st == 2) n.st = 1;
    end
    if (counted) begin
      n.tick = 1;
      if ((up && c.cnt == maxc) || (!up && c.cnt == 0)) begin
        n.wrap = 1;
        if (autos) n.st = 3;
        else       n.cnt = up ? 0 : maxc;
      end else begin
        n.cnt = up ? c.cnt + 1 : c.cnt - 1;
      end
    end
    return n;
  endfunction

  function automatic logic [11:0] exp_bits(input mdl_t x);
    return {x.tick, x.wrap, 4'(x.cnt / 10), 4'(x.cnt % 10), 2'(x.st)};
  endfunction

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], lvl, int'(rate_sel), up_dn, start, stop, clear, 99, 1'b0);
      m[1] <= mstep(m[1], lvl, int'(rate_sel), up_dn, start, stop, clear, 15, 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic pulse_start();
    @(negedge clk_50M) start = 1'b1;
    @(negedge clk_50M) start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk_50M) clear = 1'b1;
    @(negedge clk_50M) clear = 1'b0;
  endtask

  // Advance until n rises of divider k have hit a posedge; tally DUT pulses and
  // cycles where either instance diverged from the model.
  task automatic wait_rises(input int k, input int n, output int t0, output int w0,
                            output int t1, output int w1, output int mis);
    int  seen   = 0;
    int  budget = 50 * n + 20;
    bit  p      = lvl_pos[k];
    t0 = 0; w0 = 0; t1 = 0; w1 = 0; mis = 0;
    while (seen < n && budget > 0) begin
      @(posedge clk_50M);
      if (lvl[k] && !p) seen++;
      p = lvl[k];
      budget--;
      @(negedge clk_50M);
      t0 += int'(tick0); w0 += int'(wrap0);
      t1 += int'(tick1); w1 += int'(wrap1);
      if ({tick0, wrap0, tens0, ones0, state0} !== exp_bits(m[0])) mis++;
      if ({tick1, wrap1, tens1, ones1, state1} !== exp_bits(m[1])) mis++;
    end
    if (seen < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_rises_timeout: divider %0d saw %0d rises, required %0d", k, seen, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50M);
    n_cmp++;
    if ({tick0, wrap0, tens0, ones0, state0} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_wrap_inst: got %h required 000", {tick0, wrap0, tens0, ones0, state0});
    end
    n_cmp++;
    if ({tick1, wrap1, tens1, ones1, state1} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_auto_inst: got %h required 000", {tick1, wrap1, tens1, ones1, state1});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_rate();
    int t0, w0, t1, w1, mis;
    rate_sel = 2'd3; up_dn = 1'b1;
    pulse_clear();
    idle($urandom_range(1, 7));
    pulse_start();
    n_cmp++;
    if (state0 !== 2'b01) begin n_bad++; $display("FAIL rate_start_state: got %b required 01", state0); end
    wait_rises(3, 12, t0, w0, t1, w1, mis);
    n_cmp++;
    if (t0 !== 12) begin n_bad++; $display("FAIL rate10_ticks: got %0d required 12", t0); end
    n_cmp++;
    if ({tens0, ones0} !== 8'h12) begin n_bad++; $display("FAIL rate10_digits: got %h required 12", {tens0, ones0}); end
    n_cmp++;
    if (mis !== 0) begin n_bad++; $display("FAIL rate10_model: %0d cycles differ, required 0", mis); end

    pulse_clear();
    rate_sel = 2'd0;
    idle($urandom_range(1, 5));
    pulse_start();
    wait_rises(0, 3, t0, w0, t1, w1, mis);
    n_cmp++;
    if (t0 !== 3) begin n_bad++; $display("FAIL rate1_ticks: got %0d required 3", t0); end
    n_cmp++;
    if ({tens0, ones0} !== 8'h03) begin n_bad++; $display("FAIL rate1_digits: got %h required 03", {tens0, ones0}); end
    n_cmp++;
    if (mis !== 0) begin n_bad++; $display("FAIL rate1_model: %0d cycles differ, required 0", mis); end
  endtask

  task automatic test_reset_mid_run();
    int t0, w0, t1, w1, mis;
    pulse_clear();
    rate_sel = 2'd3;
    idle(1);
    pulse_start();
    wait_rises(3, 7, t0, w0, t1, w1, mis);
    n_cmp++;
    if ({tens0, ones0, state0} !== {8'h07, 2'b01}) begin
      n_bad++; $display("FAIL midrun_pre: got %h%b required 07 01", {tens0, ones0}, state0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tick0, wrap0, tens0, ones0, state0, tick1, wrap1, tens1, ones1, state1} !== 24'd0) begin
      n_bad++; $display("FAIL midrun_async_reset: outputs not all zero (%h)", {tens0, ones0, state0});
    end
    @(negedge clk_50M) rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_wrap_up();
    int t0, w0, t1, w1, mis;
    pulse_clear();
    rate_sel = 2'd3; up_dn = 1'b1;
    idle(1);
    pulse_start();
    wait_rises(3, 101, t0, w0, t1, w1, mis);
    n_cmp++;
    if (w0 !== 1) begin n_bad++; $display("FAIL wrap_up_count: got %0d wrap pulses required 1", w0); end
    n_cmp++;
    if ({tens0, ones0} !== 8'h01) begin n_bad++; $display("FAIL wrap_up_final: got %h required 01", {tens0, ones0}); end
    n_cmp++;
    if (mis !== 0) begin n_bad++; $display("FAIL wrap_up_model: %0d cycles differ, required 0", mis); end
  endtask

  task automatic test_wrap_down();
    int t0, w0, t1, w1, mis;
    pulse_clear();
    up_dn = 1'b0;
    pulse_start();
    wait_rises(3, 1, t0, w0, t1, w1, mis);
    n_cmp++;
    if ({wrap0, tens0, ones0} !== {1'b1, 8'h99}) begin
      n_bad++; $display("FAIL wrap_down_first: got wrap=%b %h required wrap=1 99", wrap0, {tens0, ones0});
    end
    wait_rises(3, 1, t0, w0, t1, w1, mis);
    n_cmp++;
    if ({w0, tens0, ones0} !== {32'd0, 8'h98}) begin
      n_bad++; $display("FAIL wrap_down_second: got wraps=%0d %h required 0 98", w0, {tens0, ones0});
    end
  endtask

  task automatic test_collision();
    int  t0, w0, t1, w1, mis, snap, budget;
    bit  low1;
    logic [1:0] other;
    up_dn = 1'b1;
    snap = m[0].cnt;
    low1 = 1'b0;
    budget = 40;
    // Two consecutive low samples of the 4-cycle divider mean the next negedge raises it.
    while (budget > 0) begin
      @(posedge clk_50M);
      if (!lvl[3] && low1) break;
      low1 = !lvl[3];
      budget--;
    end
    @(negedge clk_50M) stop = 1'b1;
    @(negedge clk_50M) stop = 1'b0;
    n_cmp++;
    if ({tick0, tens0, ones0, state0} !== {1'b0, 4'(snap / 10), 4'(snap % 10), 2'b10}) begin
      n_bad++; $display("FAIL collision: got tick=%b %h st=%b required tick=0 %0d st=10",
                        tick0, {tens0, ones0}, state0, snap);
    end
    rate_sel = 2'd1;
    idle(2);
    pulse_start();
    snap = m[0].cnt;
    wait_rises(1, 2, t0, w0, t1, w1, mis);
    n_cmp++;
    if ({tens0, ones0} !== {4'(((snap + 2) % 100) / 10), 4'((snap + 2) % 10)}) begin
      n_bad++; $display("FAIL rate2_after_pause: got %h required %0d", {tens0, ones0}, (snap + 2) % 100);
    end
    other = 2'($urandom_range(0, 2));
    if (other == 2'd1) other = 2'd3;
    rate_sel = other;
    wait_rises(1, 2, t0, w0, t1, w1, mis);
    n_cmp++;
    if (t0 !== 2 || {tens0, ones0} !== {4'(((snap + 4) % 100) / 10), 4'((snap + 4) % 10)}) begin
      n_bad++; $display("FAIL rate_change_in_run: got ticks=%0d %h required 2 %0d",
                        t0, {tens0, ones0}, (snap + 4) % 100);
    end
    n_cmp++;
    if (mis !== 0) begin n_bad++; $display("FAIL collision_model: %0d cycles differ, required 0", mis); end
  endtask

  task automatic test_auto_stop();
    int t0, w0, t1, w1, mis;
    pulse_clear();
    up_dn = 1'b1; rate_sel = 2'd3;
    idle(1);
    pulse_start();
    wait_rises(3, 15, t0, w0, t1, w1, mis);
    n_cmp++;
    if ({w1, tens1, ones1, state1} !== {32'd0, 8'h15, 2'b01}) begin
      n_bad++; $display("FAIL auto_pre_term: got wraps=%0d %h st=%b required 0 15 01", w1, {tens1, ones1}, state1);
    end
    wait_rises(3, 1, t0, w0, t1, w1, mis);
    n_cmp++;
    if ({t1, w1, tens1, ones1, state1} !== {32'd1, 32'd1, 8'h15, 2'b11}) begin
      n_bad++; $display("FAIL auto_term: got ticks=%0d wraps=%0d %h st=%b required 1 1 15 11",
                        t1, w1, {tens1, ones1}, state1);
    end
    wait_rises(3, 5, t0, w0, t1, w1, mis);
    pulse_start();
    n_cmp++;
    if ({t1, tens1, ones1, state1} !== {32'd0, 8'h15, 2'b11}) begin
      n_bad++; $display("FAIL auto_hold: got ticks=%0d %h st=%b required 0 15 11", t1, {tens1, ones1}, state1);
    end
    pulse_clear();
    n_cmp++;
    if ({tens1, ones1, state1} !== {8'h00, 2'b00}) begin
      n_bad++; $display("FAIL auto_clear: got %h st=%b required 00 00", {tens1, ones1}, state1);
    end
    n_cmp++;
    if (mis !== 0) begin n_bad++; $display("FAIL auto_model: %0d cycles differ, required 0", mis); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_50M);
      n_cmp++;
      if ({tick0, wrap0, tens0, ones0, state0} !== exp_bits(m[0])) begin
        n_bad++; $display("FAIL random_wrap_inst cyc %0d: got %h required %h",
                          i, {tick0, wrap0, tens0, ones0, state0}, exp_bits(m[0]));
      end
      n_cmp++;
      if ({tick1, wrap1, tens1, ones1, state1} !== exp_bits(m[1])) begin
        n_bad++; $display("FAIL random_auto_inst cyc %0d: got %h required %h",
                          i, {tick1, wrap1, tens1, ones1, state1}, exp_bits(m[1]));
      end
      if ($urandom_range(0, 7) == 0) rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      start = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk_50M);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rate();
    test_reset_mid_run();
    test_wrap_up();
    test_wrap_down();
    test_collision();
    test_auto_stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
